// File: rtl/bcd_serial_add_ctrl.sv
// Serial sequencer for a 2-digit BCD adder slice: adds packed multi-byte BCD operands one byte
// per cycle, least-significant byte first, with start/busy/done handshake and non-BCD detection.
module bcd_serial_add_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [8*NBYTES-1:0]   i_a,
  input  logic [8*NBYTES-1:0]   i_b,
  input  logic                  i_cin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [8*NBYTES-1:0]   o_sum,
  output logic                  o_cout,
  output logic                  o_invalid
);

  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                r_state;
  logic [IdxW-1:0]       r_idx;
  logic [8*NBYTES-1:0]   r_a;
  logic [8*NBYTES-1:0]   r_b;
  logic                  r_carry;
  logic                  r_busy;
  logic                  r_done;
  logic [8*NBYTES-1:0]   r_sum;
  logic                  r_cout;
  logic                  r_invalid;

  logic [7:0]            w_a_byte;
  logic [7:0]            w_b_byte;
  logic [4:0]            w_lo;
  logic [4:0]            w_hi;
  logic                  w_invalid;

  // Returns {digit_carry, result_digit}; out-of-range inputs follow the same rule.
  function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    logic [4:0] t;
    logic [4:0] t6;
    t  = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    t6 = t + 5'd6;
    if (t > 5'd9) begin
      bcd_digit = {1'b1, t6[3:0]};
    end else begin
      bcd_digit = {1'b0, t[3:0]};
    end
  endfunction

  always_comb begin
    w_a_byte = r_a[8*r_idx +: 8];
    w_b_byte = r_b[8*r_idx +: 8];
    w_lo     = bcd_digit(w_a_byte[3:0], w_b_byte[3:0], r_carry);
    w_hi     = bcd_digit(w_a_byte[7:4], w_b_byte[7:4], w_lo[4]);
  end

  always_comb begin
    w_invalid = 1'b0;
    for (int unsigned i = 0; i < 2 * NBYTES; i++) begin
      w_invalid = w_invalid | (i_a[4*i +: 4] > 4'd9) | (i_b[4*i +: 4] > 4'd9);
    end
  end

  // Outputs lag the state by one edge so done and busy-release land after the last byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state   <= StRun;
            r_busy    <= 1'b1;
            r_a       <= i_a;
            r_b       <= i_b;
            r_carry   <= i_cin;
            r_idx     <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_invalid <= w_invalid;
          end else begin
            r_busy <= 1'b0;
          end
        end
        StRun: begin
          r_sum[8*r_idx +: 8] <= {w_hi[3:0], w_lo[3:0]};
          r_carry             <= w_hi[4];
          r_idx               <= r_idx + 1'b1;
          if (r_idx == LastIdx) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b1;
          r_cout  <= r_carry;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_sum     = r_sum;
  assign o_cout    = r_cout;
  assign o_invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: directed operands with hand-computed results,
// a done-driven monitor, latency/hold checks, ignored restarts and a mid-run reset.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           cin = 1'b0;
  logic [8*N-1:0] a = '0;
  logic [8*N-1:0] b = '0;
  logic           busy;
  logic           done;
  logic [8*N-1:0] sum;
  logic           cout;
  logic           invalid;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;

  bcd_serial_add_ctrl #(.NBYTES(N)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_a       (a),
    .i_b       (b),
    .i_cin     (cin),
    .o_busy    (busy),
    .o_done    (done),
    .o_sum     (sum),
    .o_cout    (cout),
    .o_invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 with no pending operation, expected done=0");
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("cout", {31'd0, cout}, {31'd0, e.cout});
        check("invalid", {31'd0, invalid}, {31'd0, e.inv});
      end
    end
  end

  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                        input logic [31:0] es, input logic ec, input logic ei, input bit poke);
    int lat;
    int d0;
    @(negedge clk);
    start = 1'b1;
    a     = oa;
    b     = ob;
    cin   = oc;
    sb.push_back(exp_t'{sum: es, cout: ec, inv: ei});
    d0 = n_done;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cin   = 1'($urandom);
    check("busy_on_accept", {31'd0, busy}, 32'd1);
    check("sum_cleared", sum, 32'd0);
    check("cout_cleared", {31'd0, cout}, 32'd0);
    check("invalid_latched", {31'd0, invalid}, {31'd0, ei});
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (poke && lat <= 2) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_latency", lat, 32'd5);
    @(negedge clk);
    check("busy_released", {31'd0, busy}, 32'd0);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("invalid_held", {31'd0, invalid}, {31'd0, ei});
    check("sum_held", sum, es);
    @(negedge clk);
    check("done_count", n_done - d0, 32'd1);
  endtask

  initial begin
    int d0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_invalid", {31'd0, invalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0);
    run_op(32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op(32'h00000004, 32'h00000005, 1'b0, 32'h00000009, 1'b0, 1'b0, 1'b0);
    run_op(32'h00000004, 32'h00000005, 1'b1, 32'h00000010, 1'b0, 1'b0, 1'b0);
    run_op(32'h0000000A, 32'h00000000, 1'b0, 32'h00000010, 1'b0, 1'b1, 1'b0);
    run_op(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);
    // Restart requests during RUN must be dropped.
    run_op(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b1);

    // Abort in the second RUN cycle.
    @(negedge clk);
    start = 1'b1;
    a     = 32'h55555555;
    b     = 32'h55555555;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    d0    = n_done;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", sum, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_invalid", {31'd0, invalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done - d0, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);
    run_op(32'h55555555, 32'h55555555, 1'b0, 32'h11111110, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
